adc_capture: RTL

- Clocked TSC-side controller that drives the ADC's req/rst handshake and captures each returned 8-bit sample into a local buffer.
- Stops on the 255 end-of-stream marker, on a full buffer, or on a handshake timeout.
- Holds a running maximum of captured samples.
- Exposes the buffer through a registered read port for downstream TSC logic.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_buf.sv | 38 +++
 rtl/adc_capture.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC capture controller.
package adc_pkg;

  typedef logic [7:0] sample_t;

  localparam sample_t END_MARK_DEFAULT = 8'd255;

  typedef enum logic [2:0] {
    StIdle,
    StArst,
    StReq,
    StWait,
    StStore,
    StDone
  } state_e;

endpackage

// File: rtl/adc_buf.sv
// Sample buffer: simple dual-port RAM, one write port, one registered read port.
module adc_buf
  import adc_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  sample_t mem_q [DEPTH];
  sample_t rdata_q;

  // Storage has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-before-write: same-address read in a write cycle returns old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// ADC capture controller: drives the ADC rst/req handshake, stores returned samples
// into a local buffer and tracks the running maximum.
module adc_capture
  import adc_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter logic [7:0]  END_MARK = END_MARK_DEFAULT,
  parameter int unsigned REQ_HOLD = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       adc_rst,
  output logic                       adc_req,
  input  logic                       adc_rdy,
  input  logic [7:0]                 adc_dat,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 max_val,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [7:0]                 rd_data
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned TMaxV = (TIMEOUT > REQ_HOLD) ? TIMEOUT : REQ_HOLD;
  localparam int unsigned TW    = $clog2(TMaxV + 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            got_q, got_d;
  sample_t         sample_q, sample_d;
  logic [CW-1:0]   count_q, count_d;
  sample_t         max_q, max_d;
  logic            err_q, err_d;
  logic            rdy_meta_q, rdy_s_q;
  logic            adc_rst_q, adc_rst_d;
  logic            adc_req_q, adc_req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            we;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    got_d    = got_q;
    sample_d = sample_q;
    count_d  = count_q;
    max_d    = max_q;
    err_d    = err_q;
    we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StArst;
          tmr_d   = '0;
          count_d = '0;
          max_d   = '0;
          err_d   = 1'b0;
        end
      end
      // tmr_q == 0: adc_rst pulse cycle; tmr_q == 1: quiet cycle before the first request.
      StArst: begin
        if (tmr_q == '0) begin
          tmr_d = TW'(1);
        end else begin
          state_d = StReq;
          tmr_d   = TW'(REQ_HOLD - 1);
          got_d   = 1'b0;
        end
      end
      StReq: begin
        if (rdy_s_q) begin
          got_d    = 1'b1;
          sample_d = adc_dat;
        end
        if (tmr_q == '0) begin
          tmr_d   = '0;
          state_d = (got_q || rdy_s_q) ? StStore : StWait;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      StWait: begin
        if (rdy_s_q) begin
          sample_d = adc_dat;
          state_d  = StStore;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StStore: begin
        we      = 1'b1;
        count_d = count_q + CW'(1);
        if (sample_q != END_MARK && sample_q > max_q) begin
          max_d = sample_q;
        end
        if (sample_q == END_MARK || count_q == CW'(DEPTH - 1)) begin
          state_d = StDone;
        end else begin
          state_d = StReq;
          tmr_d   = TW'(REQ_HOLD - 1);
          got_d   = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake/status outputs are registered decodes of the next state (glitch-free to the ADC).
  always_comb begin
    adc_rst_d = (state_d == StArst) && (tmr_d == '0);
    adc_req_d = (state_d == StReq);
    busy_d    = (state_d != StIdle) && (state_d != StDone);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      got_q      <= 1'b0;
      sample_q   <= '0;
      count_q    <= '0;
      max_q      <= '0;
      err_q      <= 1'b0;
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      adc_rst_q  <= 1'b0;
      adc_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      got_q      <= got_d;
      sample_q   <= sample_d;
      count_q    <= count_d;
      max_q      <= max_d;
      err_q      <= err_d;
      rdy_meta_q <= adc_rdy;
      rdy_s_q    <= rdy_meta_q;
      adc_rst_q  <= adc_rst_d;
      adc_req_q  <= adc_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  adc_buf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (we),
    .waddr_i(count_q[AW-1:0]),
    .wdata_i(sample_q),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign adc_rst = adc_rst_q;
  assign adc_req = adc_req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign count   = count_q;
  assign max_val = max_q;

endmodule
